gouram_trace_buffer: RTL

- Sits directly downstream of the gouram trace unit; captures each 128-bit trace record it emits into a DEPTH-entry FIFO.
- Drains records as four 32-bit beats on a valid/ready stream toward the trace offload path (debug port / DMA).
- Absorbs bursts of retired-instruction records while the consumer stalls; counts records lost to overflow.

---
 rtl/gouram_trace_buffer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/gouram_trace_buffer.sv
// ============================================================================
// Module  : gouram_trace_buffer
// Brief   : FIFO for gouram trace records, drained as 4-beat valid/ready stream
// Revision: 1.0
// ============================================================================
`default_nettype none

module gouram_trace_buffer #(
  parameter int TRACE_WIDTH = 128,
  parameter int OUT_WIDTH   = 32,
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   trace_valid_i,
  input  logic [TRACE_WIDTH-1:0] trace_data_i,
  output logic                   fifo_full_o,
  output logic [ADDR_W:0]        level_o,
  output logic                   m_valid_o,
  output logic [OUT_WIDTH-1:0]   m_data_o,
  output logic                   m_last_o,
  input  logic                   m_ready_i,
  output logic [15:0]            overflow_count_o,
  input  logic                   clear_overflow_i
);

  localparam logic [0:0]      c_idle  = 1'b0;
  localparam logic [0:0]      c_send  = 1'b1;
  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

  logic [TRACE_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]        level_q, level_d;
  logic                   full_q;
  logic [0:0]             state_q, state_d;
  logic [1:0]             beat_q, beat_d;
  logic [TRACE_WIDTH-1:0] hold_q;
  logic [15:0]            ovf_q, ovf_d;
  logic                   pop, push, drop;
  logic [OUT_WIDTH-1:0]   beats [4];

  for (genvar g = 0; g < 4; g++) begin : g_beat
    assign beats[g] = hold_q[g*OUT_WIDTH +: OUT_WIDTH];
  end

  // Output sequencer: a pop always coincides with loading the holding register.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pop     = 1'b0;
    case (state_q)
      c_idle: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          beat_d  = 2'd0;
          state_d = c_send;
        end
      end
      c_send: begin
        if (m_ready_i) begin
          if (beat_q != 2'd3) begin
            beat_d = beat_q + 2'd1;
          end else if (level_q != '0) begin
            pop    = 1'b1;
            beat_d = 2'd0;
          end else begin
            state_d = c_idle;
          end
        end
      end
      default: state_d = c_idle;
    endcase
  end

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign push = trace_valid_i && ((level_q != c_depth) || pop);
  assign drop = trace_valid_i && !push;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (clear_overflow_i) begin
      ovf_d = drop ? 16'd1 : 16'd0;
    end else if (drop && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= trace_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      state_q  <= c_idle;
      beat_q   <= 2'd0;
      hold_q   <= '0;
      ovf_q    <= 16'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        hold_q   <= mem_q[rd_ptr_q];
      end
      level_q <= level_d;
      full_q  <= (level_d == c_depth);
      state_q <= state_d;
      beat_q  <= beat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign m_valid_o        = (state_q == c_send);
  assign m_data_o         = m_valid_o ? beats[beat_q] : '0;
  assign m_last_o         = m_valid_o && (beat_q == 2'd3);
  assign level_o          = level_q;
  assign fifo_full_o      = full_q;
  assign overflow_count_o = ovf_q;

endmodule

`default_nettype wire
